// File: rtl/prng_if.sv
// Seed/output bundle for the prng stimulus source.
// The master drives the seed and consumes the pseudo-random value.
interface prng_if;
    logic [4:0]  seed;
    logic [15:0] random_out;

    modport master (output seed, input random_out);
    modport slave  (input seed, output random_out);
endinterface

// File: rtl/prng.sv
// 5-bit maximal-length LFSR (x^5 + x^3 + 1) mapped onto ten evenly spaced
// fractions k/9, emitted as unsigned Q5.11 values (1.0 = 16'h0800).
module prng (
    input  logic   clk,
    input  logic   rst,
    prng_if.slave  bus
);
    logic [4:0]  lfsr_reg;
    logic [4:0]  lfsr_next;
    logic [4:0]  seed_load;
    logic [3:0]  k_idx;
    logic [15:0] random_out_reg;
    logic [15:0] random_out_next;
    logic [15:0] table_val [10];

    // floor(k*2048/9) for k = 0..9, folded to constants at elaboration
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_table
            assign table_val[gi] = 16'((gi * 2048) / 9);
        end
    endgenerate

    // The all-zero state would lock the LFSR, so a zero seed loads 1
    always_comb begin
        seed_load = bus.seed;
        if (bus.seed == 5'd0) begin
            seed_load = 5'd1;
        end
    end

    always_comb begin
        lfsr_next       = {lfsr_reg[3:0], lfsr_reg[4] ^ lfsr_reg[2]};
        k_idx           = 4'(lfsr_reg % 5'd10);
        random_out_next = table_val[k_idx];
    end

    // Seed is only loaded while reset is held; run-time seed changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= seed_load;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_out_reg <= 16'h0000;
        end else begin
            random_out_reg <= random_out_next;
        end
    end

    assign bus.random_out = random_out_reg;
endmodule

// File: tb/tb_prng.sv
// Directed bench for prng: hand-computed sequences, histogram and reset cases.
module tb_prng;
    logic clk;
    logic rst;
    int   vec_count;
    int   err_count;

    prng_if bus_if ();

    prng dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived outputs for seed 9: lfsr 9,18,5,11,22,12,25,19
    logic [15:0] exp_seed9 [8] = '{16'h0800, 16'h071C, 16'h0471, 16'h00E3,
                                   16'h01C7, 16'h01C7, 16'h0471, 16'h0800};
    logic [15:0] exp_seed1 [4] = '{16'h00E3, 16'h01C7, 16'h038E, 16'h0800};
    logic [15:0] tbl [10] = '{16'h0000, 16'h00E3, 16'h01C7, 16'h02AA, 16'h038E,
                              16'h0471, 16'h0555, 16'h0638, 16'h071C, 16'h0800};
    int          exp_hist [10] = '{3, 4, 3, 3, 3, 3, 3, 3, 3, 3};

    // Hold reset for two negedges with the given seed, release at a negedge
    task automatic start(input logic [4:0] s);
        @(negedge clk);
        bus_if.seed = s;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        bus_if.seed = 5'd9;
        rst = 1'b0;
        #1;
        vec_count++;
        if (bus_if.random_out !== 16'h0000) begin
            err_count++;
            $display("FAIL reset_async got=%h want=%h", bus_if.random_out, 16'h0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_count++;
            if (bus_if.random_out !== 16'h0000) begin
                err_count++;
                $display("FAIL reset_hold[%0d] got=%h want=%h", i, bus_if.random_out, 16'h0000);
            end
            $display("reset_hold[%0d] out=%h", i, bus_if.random_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_seed9;
        start(5'd9);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec_count++;
            if (bus_if.random_out !== exp_seed9[i]) begin
                err_count++;
                $display("FAIL seed9[%0d] got=%h want=%h", i, bus_if.random_out, exp_seed9[i]);
            end
            $display("seed9[%0d] out=%h", i, bus_if.random_out);
        end
    endtask

    task automatic test_seed0;
        start(5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec_count++;
            if (bus_if.random_out !== exp_seed1[i]) begin
                err_count++;
                $display("FAIL seed0[%0d] got=%h want=%h", i, bus_if.random_out, exp_seed1[i]);
            end
            $display("seed0[%0d] out=%h", i, bus_if.random_out);
        end
    endtask

    task automatic test_histogram;
        int hist [10];
        int bad;
        bool_loop: begin end
        bad = 0;
        for (int k = 0; k < 10; k++) hist[k] = 0;
        start(5'd9);
        for (int i = 0; i < 31; i++) begin
            bit hit;
            @(negedge clk);
            hit = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (bus_if.random_out === tbl[k]) begin
                    hist[k]++;
                    hit = 1'b1;
                end
            end
            if (!hit) bad++;
        end
        for (int k = 0; k < 10; k++) begin
            vec_count++;
            if (hist[k] !== exp_hist[k]) begin
                err_count++;
                $display("FAIL hist_k%0d got=%0d want=%0d", k, hist[k], exp_hist[k]);
            end
            $display("hist k%0d value=%h count=%0d", k, tbl[k], hist[k]);
        end
        vec_count++;
        if (bad !== 0) begin
            err_count++;
            $display("FAIL hist_nontable got=%0d want=%0d", bad, 0);
        end
        @(negedge clk);
        vec_count++;
        if (bus_if.random_out !== 16'h0800) begin
            err_count++;
            $display("FAIL wrap_32nd got=%h want=%h", bus_if.random_out, 16'h0800);
        end
        $display("wrap_32nd out=%h", bus_if.random_out);
    endtask

    task automatic test_seed_in_reset;
        @(negedge clk);
        bus_if.seed = 5'd9;
        rst = 1'b0;
        @(negedge clk);
        bus_if.seed = 5'd7;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec_count++;
        if (bus_if.random_out !== 16'h0638) begin
            err_count++;
            $display("FAIL seed_in_reset got=%h want=%h", bus_if.random_out, 16'h0638);
        end
        $display("seed_in_reset out=%h", bus_if.random_out);
    endtask

    task automatic test_midrun_reset;
        start(5'd9);
        for (int i = 0; i < 3; i++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vec_count++;
        if (bus_if.random_out !== 16'h0000) begin
            err_count++;
            $display("FAIL midrun_async got=%h want=%h", bus_if.random_out, 16'h0000);
        end
        $display("midrun_async out=%h", bus_if.random_out);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec_count++;
            if (bus_if.random_out !== exp_seed9[i]) begin
                err_count++;
                $display("FAIL midrun_restart[%0d] got=%h want=%h", i, bus_if.random_out, exp_seed9[i]);
            end
            $display("midrun_restart[%0d] out=%h", i, bus_if.random_out);
        end
    endtask

    task automatic test_seed_while_running;
        start(5'd9);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_if.seed = 5'(i * 7 + 3);
            vec_count++;
            if (bus_if.random_out !== exp_seed9[i]) begin
                err_count++;
                $display("FAIL seed_run[%0d] got=%h want=%h", i, bus_if.random_out, exp_seed9[i]);
            end
            $display("seed_run[%0d] out=%h", i, bus_if.random_out);
        end
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        rst = 1'b1;
        bus_if.seed = 5'd9;
        test_reset();
        test_seed9();
        test_seed0();
        test_histogram();
        test_seed_in_reset();
        test_midrun_reset();
        test_seed_while_running();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
